// File: rtl/rib_arbiter.sv
// Three-master bus arbiter (m0 = ex load/store, m1 = fetch, m2 = debug) with
// one registered grant per transaction and a watchdog. `RIB_ARB_RR_EN selects round-robin.
module rib_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_ack_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_ack_o,
    input  logic              m2_req_i,
    input  logic              m2_we_i,
    input  logic [ADDR_W-1:0] m2_addr_i,
    input  logic [DATA_W-1:0] m2_wdata_i,
    output logic [DATA_W-1:0] m2_rdata_o,
    output logic              m2_ack_o,
    output logic              s_req_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic [DATA_W-1:0] s_rdata_i,
    input  logic              s_ack_i,
    output logic              hold_flag_o,
    output logic              err_o
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [7:0]        wd_cnt_q, wd_cnt_d;
    logic [1:0]        win;
    logic [2:0]        req_vec;
    logic [2:0]        ack_vec;
    logic              busy, done_ack, wd_fire, fin;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [DATA_W-1:0] rdata_mux;

    assign req_vec  = {m2_req_i, m1_req_i, m0_req_i};
    assign busy     = (state_q == BUSY);
    assign done_ack = busy & s_ack_i;
    // A slave ack landing on the last watchdog cycle takes precedence.
    assign wd_fire  = busy & ~s_ack_i & (wd_cnt_q == WD_LAST);
    assign fin      = done_ack | wd_fire;

`ifdef RIB_ARB_RR_EN
    logic [1:0] last_grant_q, last_grant_d;

    always_comb begin
        logic [1:0] start;
        logic [1:0] cand;
        logic [2:0] sum;
        logic       found;
        start = (last_grant_q == 2'd2) ? 2'd0 : last_grant_q + 2'd1;
        cand  = start;
        sum   = 3'd0;
        found = 1'b0;
        win   = start;
        for (int i = 0; i < 3; i++) begin
            sum  = {1'b0, start} + 3'(i);
            cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!found && req_vec[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win = 2'd0;
        if (m2_req_i)      win = 2'd2;
        else if (m0_req_i) win = 2'd0;
        else if (m1_req_i) win = 2'd1;
    end
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        wd_cnt_d = wd_cnt_q;
`ifdef RIB_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    state_d  = BUSY;
                    grant_d  = win;
                    wd_cnt_d = 8'd0;
`ifdef RIB_ARB_RR_EN
                    last_grant_d = win;
`endif
                end
            end
            BUSY: begin
                if (fin) state_d = IDLE;
                else     wd_cnt_d = wd_cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= 2'd0;
            wd_cnt_q <= 8'd0;
`ifdef RIB_ARB_RR_EN
            last_grant_q <= 2'd2;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            wd_cnt_q <= wd_cnt_d;
`ifdef RIB_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    always_comb begin
        case (grant_q)
            2'd0:    begin g_we = m0_we_i; g_addr = m0_addr_i; g_wdata = m0_wdata_i; end
            2'd1:    begin g_we = m1_we_i; g_addr = m1_addr_i; g_wdata = m1_wdata_i; end
            default: begin g_we = m2_we_i; g_addr = m2_addr_i; g_wdata = m2_wdata_i; end
        endcase
    end

    always_comb begin
        s_req_o   = busy;
        s_we_o    = busy & g_we;
        s_addr_o  = busy ? g_addr : '0;
        s_wdata_o = busy ? g_wdata : '0;
        ack_vec   = fin ? (3'b001 << grant_q) : 3'b000;
        // Watchdog completions return zero data.
        rdata_mux = done_ack ? s_rdata_i : '0;
        m0_ack_o  = ack_vec[0];
        m1_ack_o  = ack_vec[1];
        m2_ack_o  = ack_vec[2];
        m0_rdata_o = ack_vec[0] ? rdata_mux : '0;
        m1_rdata_o = ack_vec[1] ? rdata_mux : '0;
        m2_rdata_o = ack_vec[2] ? rdata_mux : '0;
        err_o     = wd_fire;
        // Gated by rst so the stall drops while reset is held, even with requests up.
        hold_flag_o = rst & ((m0_req_i & ~ack_vec[0]) | (m1_req_i & ~ack_vec[1]) |
                             (busy & (grant_q == 2'd2)));
    end
endmodule

// File: tb/tb_rib_arbiter.sv
// Scoreboard bench for rib_arbiter: stimulus pushes expected slave requests,
// acks and hold_flag values; a negedge monitor pops and compares them.
module tb_rib_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req[3];
    logic        we[3];
    logic [31:0] addr[3];
    logic [31:0] wdata[3];
    logic [31:0] m0_rdata, m1_rdata, m2_rdata;
    logic        m0_ack, m1_ack, m2_ack;
    logic        s_req_o, s_we_o, s_ack_i, hold_flag_o, err_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;

    typedef struct {int m; logic [31:0] rdata; logic err; int cyc;} ack_exp_t;
    typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; int cyc;} s_exp_t;
    typedef struct {logic val; int cyc;} hold_exp_t;

    ack_exp_t  a_q[$];
    s_exp_t    s_q[$];
    hold_exp_t h_q[$];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          slave_lat = 1;
    logic [31:0] slave_data = 32'h0000_1234;
    logic        done = 1'b0;
    logic        cont = 1'b0;
    int          nacks;

    rib_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
        .m0_rdata_o(m0_rdata), .m0_ack_o(m0_ack),
        .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
        .m1_rdata_o(m1_rdata), .m1_ack_o(m1_ack),
        .m2_req_i(req[2]), .m2_we_i(we[2]), .m2_addr_i(addr[2]), .m2_wdata_i(wdata[2]),
        .m2_rdata_o(m2_rdata), .m2_ack_o(m2_ack),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i),
        .hold_flag_o(hold_flag_o), .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_of(int m);
        case (m)
            0:       return m0_rdata;
            1:       return m1_rdata;
            default: return m2_rdata;
        endcase
    endfunction

    // Slave model: acks on the slave_lat-th BUSY cycle; slave_lat==0 never acks.
    initial begin
        int scnt;
        scnt = 0;
        s_ack_i = 1'b0;
        s_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (s_req_o) scnt++;
            else         scnt = 0;
            if (s_req_o && slave_lat != 0 && scnt == slave_lat) begin
                s_ack_i = 1'b1; s_rdata_i = slave_data;
            end else begin
                s_ack_i = 1'b0; s_rdata_i = '0;
            end
        end
    end

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
        end
    endtask

    // Monitor
    initial begin
        logic      sreq_prev;
        logic [2:0] ack_w;
        ack_exp_t  ae;
        s_exp_t    se;
        hold_exp_t he;
        logic [31:0] others;
        sreq_prev = 1'b0;
        forever begin
            @(negedge clk);
            ack_w = {m2_ack, m1_ack, m0_ack};
            if (!rst) begin
                chk("reset_outputs", {52'd0, s_req_o, s_we_o, ack_w, hold_flag_o, err_o,
                    |s_addr_o, |s_wdata_o, |m0_rdata, |m1_rdata, |m2_rdata}, 64'd0);
            end else begin
                if (s_req_o && !sreq_prev) begin
                    if (s_q.size() == 0) chk("unexpected_s_req", 1, 0);
                    else begin
                        se = s_q.pop_front();
                        chk("s_req_cycle", cyc, se.cyc);
                        chk("s_we", s_we_o, se.we);
                        chk("s_addr", s_addr_o, se.addr);
                        chk("s_wdata", s_wdata_o, se.wdata);
                    end
                end
                if (ack_w != 3'b000) begin
                    if (a_q.size() == 0) chk("unexpected_ack", ack_w, 0);
                    else begin
                        ae = a_q.pop_front();
                        chk("ack_master", ack_w, 3'b001 << ae.m);
                        chk("ack_cycle", cyc, ae.cyc);
                        chk("ack_rdata", rd_of(ae.m), ae.rdata);
                        chk("ack_err", err_o, ae.err);
                        others = 32'd0;
                        for (int i = 0; i < 3; i++) if (i != ae.m) others |= rd_of(i);
                        chk("other_rdata", others, 0);
                    end
                end else begin
                    chk("err_no_ack", err_o, 0);
                end
                while (h_q.size() != 0 && h_q[0].cyc <= cyc) begin
                    he = h_q.pop_front();
                    if (he.cyc != cyc) chk("hold_missed", he.cyc, cyc);
                    else               chk("hold_flag", hold_flag_o, he.val);
                end
            end
            sreq_prev = s_req_o;
            if (done) begin
                chk("s_queue_left", s_q.size(), 0);
                chk("ack_queue_left", a_q.size(), 0);
                chk("hold_queue_left", h_q.size(), 0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    task automatic exp_s(logic w, logic [31:0] a, logic [31:0] d, int c);
        s_exp_t e;
        e.we = w; e.addr = a; e.wdata = d; e.cyc = c;
        s_q.push_back(e);
    endtask

    task automatic exp_ack(int m, logic [31:0] d, logic e_err, int c);
        ack_exp_t e;
        e.m = m; e.rdata = d; e.err = e_err; e.cyc = c;
        a_q.push_back(e);
    endtask

    task automatic exp_hold(logic v, int c);
        hold_exp_t e;
        e.val = v; e.cyc = c;
        h_q.push_back(e);
    endtask

    // One cycle: sample acks at negedge, then drop acked requests just after posedge.
    task automatic step();
        logic acked[3];
        @(negedge clk);
        acked[0] = m0_ack; acked[1] = m1_ack; acked[2] = m2_ack;
        @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) begin
            if (acked[m]) begin
                nacks++;
                if (!cont) req[m] = 1'b0;
            end
        end
    endtask

    task automatic run_acks(int n, int maxc);
        for (int i = 0; i < maxc && nacks < n; i++) step();
    endtask

    initial begin
        int k;
        int m;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b1; we[i] = 1'b0; wdata[i] = '0;
        end
        addr[0] = 32'h0000_0100; addr[1] = 32'h0000_0200; addr[2] = 32'h0000_0300;
        cont = 1'b1;
        slave_lat = 1;
        slave_data = 32'h0000_1234;
        repeat (3) step();

        // All three requesting continuously from reset
        rst = 1'b1;
        k = cyc;
        for (int i = 0; i < 3; i++) begin
`ifdef RIB_ARB_RR_EN
            m = i;
`else
            m = 2;
`endif
            exp_s(1'b0, addr[m], 32'd0, k + 1 + 2 * i);
            exp_ack(m, 32'h0000_1234, 1'b0, k + 1 + 2 * i);
        end
        nacks = 0;
        run_acks(3, 20);
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        cont = 1'b0;
        repeat (2) step();

        // Single m1 read, slave acks two cycles after s_req_o
        slave_lat = 3;
        slave_data = 32'hDEAD_BEEF;
        addr[1] = 32'h0000_0010;
        req[1] = 1'b1;
        k = cyc;
        exp_s(1'b0, 32'h0000_0010, 32'd0, k + 1);
        exp_ack(1, 32'hDEAD_BEEF, 1'b0, k + 3);
        nacks = 0;
        run_acks(1, 20);
        repeat (2) step();

        // m0 write and m1 read in the same cycle
        slave_lat = 1;
        slave_data = 32'h5555_AAAA;
        we[0] = 1'b1; addr[0] = 32'h1000_0004; wdata[0] = 32'h0000_00A5; req[0] = 1'b1;
        addr[1] = 32'h0000_0020; req[1] = 1'b1;
        k = cyc;
        exp_s(1'b1, 32'h1000_0004, 32'h0000_00A5, k + 1);
        exp_ack(0, 32'h5555_AAAA, 1'b0, k + 1);
        exp_s(1'b0, 32'h0000_0020, 32'd0, k + 3);
        exp_ack(1, 32'h5555_AAAA, 1'b0, k + 3);
        exp_hold(1'b1, k); exp_hold(1'b1, k + 1); exp_hold(1'b1, k + 2);
        exp_hold(1'b0, k + 3); exp_hold(1'b0, k + 4);
        nacks = 0;
        run_acks(2, 20);
        we[0] = 1'b0; wdata[0] = '0;
        repeat (3) step();

        // Slave never acks: watchdog fires on the 255th BUSY cycle
        slave_lat = 0;
        slave_data = 32'hCAFE_F00D;
        addr[0] = 32'h0000_0030; req[0] = 1'b1;
        k = cyc;
        exp_s(1'b0, 32'h0000_0030, 32'd0, k + 1);
        exp_ack(0, 32'd0, 1'b1, k + 255);
        nacks = 0;
        run_acks(1, 300);
        repeat (2) step();

        // Slave ack on the timeout cycle wins
        slave_lat = 255;
        addr[1] = 32'h0000_0040; req[1] = 1'b1;
        k = cyc;
        exp_s(1'b0, 32'h0000_0040, 32'd0, k + 1);
        exp_ack(1, 32'hCAFE_F00D, 1'b0, k + 255);
        nacks = 0;
        run_acks(1, 300);
        repeat (2) step();

        // Reset in BUSY cycle 3 of a debug write, then re-grant
        slave_lat = 0;
        we[2] = 1'b1; addr[2] = 32'h0000_0050; wdata[2] = 32'h0000_0077; req[2] = 1'b1;
        k = cyc;
        exp_s(1'b1, 32'h0000_0050, 32'h0000_0077, k + 1);
        exp_hold(1'b0, k); exp_hold(1'b1, k + 1); exp_hold(1'b1, k + 2);
        repeat (3) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        slave_lat = 1;
        exp_s(1'b1, 32'h0000_0050, 32'h0000_0077, k + 5);
        exp_ack(2, 32'hCAFE_F00D, 1'b0, k + 5);
        exp_hold(1'b0, k + 4); exp_hold(1'b1, k + 5);
        nacks = 0;
        run_acks(1, 20);
        repeat (2) step();

        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL monitor did not reach summary");
        $fatal(1);
    end
endmodule
